// File: rtl/gf180mcu_buf_leg_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the buffer-leg sequencer: FSM states and the
// thermometer encoder used to derive leg enables from a leg count.
package gf180mcu_buf_leg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } leg_state_e;

    localparam int MAX_LEG = 64;

    // Low n bits set; callers truncate to their own leg count.
    function automatic logic [MAX_LEG-1:0] therm(input int unsigned n);
        logic [MAX_LEG-1:0] t;
        t = '0;
        for (int i = 0; i < MAX_LEG; i++) begin
            t[i] = (unsigned'(i) < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/gf180mcu_buf_leg_tick.sv
`timescale 1ns/1ps
// Step-interval down-counter: load a value, expire flags the cycle it sits at
// zero, so a load of N expires N+1 cycles later.
module gf180mcu_buf_leg_tick #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/gf180mcu_buf_leg_seq.sv
`timescale 1ns/1ps
// Buffer-leg sequencer: ramps a thermometer set of leg enables one leg per
// step interval towards a requested count, to limit switching transients.
module gf180mcu_buf_leg_seq
    import gf180mcu_buf_leg_pkg::*;
#(
    parameter int NLEG = 8,
    parameter int DIVW = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REQ,
    input  logic [$clog2(NLEG+1)-1:0]  TGT,
    output logic                       ACK,
    input  logic [DIVW-1:0]            DIV,
    output logic [NLEG-1:0]            EN,
    output logic [$clog2(NLEG+1)-1:0]  LVL,
    output logic                       BUSY,
    output logic                       DONE
);

    localparam int LW = $clog2(NLEG+1);
    localparam logic [LW-1:0] NLEG_L = LW'(NLEG);

    leg_state_e      state;
    logic [LW-1:0]   lvl, lvl_nxt, tgt_q, tgt_sat;
    logic [NLEG-1:0] en_q;
    logic            done_q, expire, step, load;

    assign tgt_sat = (TGT > NLEG_L) ? NLEG_L : TGT;
    assign BUSY    = (state != IDLE);
    // A request is not taken in the DONE cycle, so a held REQ lands one cycle later.
    assign ACK     = !RST && (state == IDLE) && REQ && !done_q;
    assign step    = BUSY && expire;
    assign load    = ACK || step;

    gf180mcu_buf_leg_tick #(.W(DIVW)) u_tick (
        .clk    (CLK),
        .rst    (RST),
        .load   (load),
        .value  (DIV),
        .expire (expire)
    );

    always_comb begin
        lvl_nxt = lvl;
        if (step && state == UP && lvl != NLEG_L) lvl_nxt = lvl + LW'(1);
        if (step && state == DOWN && lvl != '0)   lvl_nxt = lvl - LW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            lvl    <= '0;
            tgt_q  <= '0;
            en_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            lvl    <= lvl_nxt;
            en_q   <= NLEG'(therm(32'(lvl_nxt)));
            case (state)
                IDLE: begin
                    if (ACK) begin
                        tgt_q <= tgt_sat;
                        if (tgt_sat > lvl)      state  <= UP;
                        else if (tgt_sat < lvl) state  <= DOWN;
                        else                    done_q <= 1'b1;
                    end
                end
                UP, DOWN: begin
                    if (step && lvl_nxt == tgt_q) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign EN   = en_q;
    assign LVL  = lvl;
    assign DONE = done_q;

endmodule

// File: tb/tb_gf180mcu_buf_leg_seq.sv
`timescale 1ns/1ps
// Bench for the buffer-leg sequencer: directed ramps plus random requests,
// compared every cycle against a timestamp-based behavioural model.
module tb_gf180mcu_buf_leg_seq;

    localparam int NLEG = 8;
    localparam int DIVW = 4;
    localparam int LW   = $clog2(NLEG+1);

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            REQ = 1'b0;
    logic [LW-1:0]   TGT = '0;
    logic [DIVW-1:0] DIV = '0;
    logic            ACK, BUSY, DONE;
    logic [NLEG-1:0] EN;
    logic [LW-1:0]   LVL;

    gf180mcu_buf_leg_seq #(.NLEG(NLEG), .DIVW(DIVW)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .TGT(TGT), .ACK(ACK), .DIV(DIV),
        .EN(EN), .LVL(LVL), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Model: leg count, target, and the absolute edge number of the next step.
    int m_lvl = 0, m_tgt = 0, m_due = 0, edge_n = 0;
    bit m_busy = 0, m_done = 0;
    logic [NLEG-1:0] prev_en = '0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic int therm_of(input int n);
        return (1 << n) - 1;
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_tgt = 0; m_due = 0; m_busy = 0; m_done = 0;
        prev_en = '0;
    endtask

    // One clock: drive inputs, check ACK before the edge, advance the model, check outputs after.
    task automatic cyc(input bit req, input int tgt, input int div);
        bit exp_ack, done_nxt;
        int t;
        REQ = req; TGT = LW'(tgt); DIV = DIVW'(div);
        #1;
        exp_ack = req && !m_busy && !m_done;
        check("ack", int'(ACK), int'(exp_ack));
        if (ACK && DONE) check("ack_with_done", 1, 0);
        @(posedge CLK);
        edge_n++;
        done_nxt = 0;
        if (exp_ack) begin
            t = (tgt > NLEG) ? NLEG : tgt;
            if (t == m_lvl) done_nxt = 1;
            else begin
                m_busy = 1; m_tgt = t; m_due = edge_n + div + 1;
            end
        end else if (m_busy && edge_n == m_due) begin
            m_lvl += (m_tgt > m_lvl) ? 1 : -1;
            m_due = edge_n + div + 1;
            if (m_lvl == m_tgt) begin
                m_busy = 0; done_nxt = 1;
            end
        end
        m_done = done_nxt;
        #1;
        check("lvl", int'(LVL), m_lvl);
        check("en", int'(EN), therm_of(m_lvl));
        check("busy", int'(BUSY), int'(m_busy));
        check("done", int'(DONE), int'(m_done));
        check("en_therm_lvl", int'(EN), therm_of(int'(LVL)));
        check("en_one_bit", int'($countones(EN ^ prev_en) <= 1), 1);
        if (LVL > NLEG) check("lvl_range", int'(LVL), NLEG);
        prev_en = EN;
    endtask

    task automatic idle(input int n, input int div);
        for (int i = 0; i < n; i++) cyc(0, 0, div);
    endtask

    initial begin
        int guard;
        // Reset state, with REQ high to confirm ACK is held off.
        REQ = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_en", int'(EN), 0);
        check("rst_lvl", int'(LVL), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_ack", int'(ACK), 0);
        RST = 1'b0;
        model_reset();

        // Full ramp up at one step per cycle.
        cyc(1, 8, 0);
        idle(10, 0);
        check("up_full_en", int'(EN), 'hFF);

        // Ramp down with a 4-cycle interval.
        cyc(1, 2, 3);
        idle(26, 3);
        check("down_en", int'(EN), 'h03);

        // No-op request, then out-of-range target saturating at NLEG.
        cyc(1, 5, 0);
        idle(5, 0);
        cyc(1, 5, 1);
        idle(2, 0);
        check("noop_en", int'(EN), 'h1F);
        cyc(1, 15, 0);
        idle(6, 0);
        check("sat_lvl", int'(LVL), NLEG);

        // Busy rejection: REQ held with TGT=0 during an up-ramp to 6.
        cyc(1, 0, 0);
        idle(10, 0);
        cyc(1, 6, 1);
        for (int i = 0; i < 30; i++) cyc(1, 0, 1);
        idle(3, 0);
        check("busy_rej_lvl", int'(LVL), 0);

        // Asynchronous reset mid-ramp at LVL=4.
        cyc(1, 8, 1);
        guard = 0;
        while (LVL != 4 && guard < 40) begin
            cyc(0, 0, 1);
            guard++;
        end
        check("reach_lvl4", int'(LVL), 4);
        RST = 1'b1;
        #1;
        check("async_rst_en", int'(EN), 0);
        check("async_rst_busy", int'(BUSY), 0);
        #1;
        RST = 1'b0;
        model_reset();
        cyc(1, 3, 0);
        idle(5, 0);
        check("post_rst_en", int'(EN), 'h07);

        // Random requests, targets and intervals (DIV may change mid-ramp).
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule

// File: doc/gf180mcu_buf_leg_seq.md
GF180MCU_BUF_LEG_SEQ -- requirements
Module: gf180mcu_buf_leg_seq

Interface
REQ-001 SHALL have parameter NLEG, default 8: number of parallel buffer legs controlled.
REQ-002 SHALL have parameter DIVW, default 4: width of the step-interval divider.
REQ-003 SHALL have ports as follows (clock and reset first):
  CLK  input  1  single clock, rising-edge active.
  RST  input  1  asynchronous, active-high reset.
  REQ  input  1  target-change request valid.
  TGT  input  $clog2(NLEG+1)  requested number of enabled legs, 0..NLEG.
  ACK  output  1  one-cycle pulse: request accepted.
  DIV  input  DIVW  step interval in cycles minus 1.
  EN  output  NLEG  thermometer leg enables; EN[0] is the first leg on and the last leg off.
  LVL  output  $clog2(NLEG+1)  current count of enabled legs.
  BUSY  output  1  ramp in progress.
  DONE  output  1  one-cycle pulse: LVL has reached the target.

Function
REQ-004 SHALL contain a FSM with states IDLE, UP and DOWN.
REQ-005 In IDLE with REQ=1, SHALL pulse ACK in the same cycle and latch the target.
  - The latched target is TGT, saturated to NLEG if TGT > NLEG.
REQ-006 Next state after accepting a request in IDLE:
  - UP if target > LVL.
  - DOWN if target < LVL.
  - IDLE if target = LVL; DONE SHALL pulse in the following cycle.
REQ-007 In UP and DOWN, SHALL change LVL by exactly 1 each time the interval counter expires.
  - The counter is loaded with DIV on entry and after every step.
  - The interval is DIV+1 cycles; DIV=0 gives one step per cycle.
  - The first step occurs DIV+1 cycles after ACK.
REQ-008 In UP and DOWN, SHALL ignore REQ and hold ACK=0; no queuing.
REQ-009 SHALL sample DIV only at each counter reload.
REQ-010 SHALL return to IDLE in the cycle LVL equals the target.
  - DONE SHALL pulse for exactly one cycle, registered with that LVL update.
REQ-011 SHALL accept a new request in IDLE on the cycle after DONE.
REQ-012 SHALL register EN; EN SHALL always equal the thermometer code of LVL (low LVL bits set).
  - EN SHALL never change by more than one bit per cycle.
REQ-013 SHALL drive BUSY=1 exactly when the state is UP or DOWN.
REQ-014 SHALL keep LVL within 0..NLEG at all times.
  - No wrap-around.
  - Saturation SHALL hold for any TGT value, including out-of-range values.

Reset
REQ-015 On RST=1, asynchronously and independent of CLK, SHALL set:
  - state IDLE, LVL=0, EN=0.
  - ACK=0, DONE=0, BUSY=0.
  - Counter and latched target = 0.
REQ-016 RST asserted mid-ramp SHALL drop all legs immediately.
  - No ramp-down sequencing.
  - After RST deasserts, the block SHALL accept the first REQ on the first rising CLK edge.

Structure
REQ-017 SHALL place the state enumeration (IDLE/UP/DOWN) in the shared package gf180mcu_buf_leg_pkg.
REQ-018 SHALL place the thermometer-encode function in gf180mcu_buf_leg_pkg.
REQ-019 SHALL implement the interval counter as a single sub-module, gf180mcu_buf_leg_tick.
  - Inputs: load, value; output: expire.
REQ-020 SHALL be fully synchronous to CLK apart from RST; no combinational path from REQ to EN.

Verification
REQ-021 Ramp up: reset, DIV=0, REQ with TGT=8 -> ACK at cycle 0; EN steps 0x01,0x03,...,0xFF on cycles 1..8; DONE at cycle 8; BUSY=0 at cycle 9.
REQ-022 Ramp down with interval: from LVL=8, DIV=3, TGT=2 -> EN loses one bit every 4 cycles; final EN=0x03 after 24 cycles; single DONE pulse.
REQ-023 No-op and saturation: TGT=LVL=5 -> ACK, DONE next cycle, EN unchanged; TGT=15 -> ramps to LVL=8, never exceeds it.
REQ-024 Busy rejection: REQ held high with TGT=0 during an up-ramp to 6 -> no ACK until after DONE; then ACK and ramp down to 0.
REQ-025 Reset mid-ramp: RST pulsed at LVL=4 during an up-ramp -> EN=0x00 before the next CLK edge; a post-reset REQ with TGT=3 ramps cleanly from 0.
REQ-026 Assertions on all tests:
  - EN is thermometer-coded and consistent with LVL.
  - Hamming distance of EN between consecutive cycles is at most 1.
  - ACK and DONE are never high together with BUSY=1 at entry.
